// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: opcodes and FSM state encodings shared by the arbiter and its logic unit
package logic_unit_arbiter_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;
endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// logic_unit: combinational W-bit AND/OR/XOR/NOR selected by a 2-bit opcode
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [1:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o
);
  always_comb
    res_o = op_i == OP_AND ? a_i & b_i :
            op_i == OP_OR  ? a_i | b_i :
            op_i == OP_XOR ? a_i ^ b_i : ~(a_i | b_i);
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise logic unit among N requesters
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [2*N-1:0]    req_op,
  input  logic [W*N-1:0]    req_a,
  input  logic [W*N-1:0]    req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W-1:0]      resp_data,
  output logic [ID_W-1:0]   resp_id
);
  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, rid_q, rid_d, gnt;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, data_q, data_d, res;
  logic            vld_q, vld_d, found;
  logic [ID_W:0]   idx;
  logic [N-1:0]    rdy;
  logic_unit #(.W(W)) u_lu (.op_i(op_q), .a_i(a_q), .b_i(b_q), .res_o(res));
  // scan from rr_q upward, wrapping N-1 -> 0 explicitly for non-power-of-2 N
  always_comb begin
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_q} + (ID_W+1)'(k);
      idx = idx >= (ID_W+1)'(N) ? idx - (ID_W+1)'(N) : idx;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        gnt = idx[ID_W-1:0];
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    id_d = id_q;
    data_d = data_q;
    rid_d = rid_q;
    vld_d = vld_q;
    rdy = '0;
    case (state_q)
      ST_IDLE: if (found) begin
        rdy = N'(1) << gnt;
        op_d = req_op[2*gnt +: 2];
        a_d = req_a[W*gnt +: W];
        b_d = req_b[W*gnt +: W];
        id_d = gnt;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        data_d = res;
        rid_d = id_q;
        vld_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (resp_ready) begin
        vld_d = 1'b0;
        rr_d = id_q == ID_W'(N-1) ? '0 : id_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // keep the accept strobe quiet while reset is held, even though state reads IDLE
  assign req_ready  = rst_n ? rdy : '0;
  assign resp_valid = vld_q;
  assign resp_data  = data_q;
  assign resp_id    = rid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      id_q <= '0;
      data_q <= '0;
      rid_q <= '0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      id_q <= id_d;
      data_q <= data_d;
      rid_q <= rid_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: table-driven transactions plus backpressure and reset corner sequences
module tb_logic_unit_arbiter;
  localparam int N = 4, W = 32, ID_W = 2;
  logic              clk, rst_n, resp_valid, resp_ready;
  logic [N-1:0]      req_valid, req_ready;
  logic [2*N-1:0]    req_op;
  logic [W*N-1:0]    req_a, req_b;
  logic [W-1:0]      resp_data;
  logic [ID_W-1:0]   resp_id;
  int errors = 0, checks = 0;

  logic_unit_arbiter #(.N(N), .W(W), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  exp_ready;
    logic [31:0] exp_data;
    logic [1:0]  exp_id;
    bit          hold;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_all(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = op;
      req_a[W*i +: W] = a;
      req_b[W*i +: W] = b;
    end
  endtask

  // entered and left at a negedge with the DUT in IDLE; three clocks per transaction
  task automatic txn(input vec_t v);
    req_valid = v.valid;
    drive_all(v.op, v.a, v.b);
    resp_ready = 1'b1;
    #1 chk("accept_ready", 32'(req_ready), 32'(v.exp_ready));
    @(negedge clk);
    chk("exec_ready", 32'(req_ready), 32'h0);
    chk("exec_rvalid", 32'(resp_valid), 32'h0);
    if (!v.hold) req_valid = '0;
    @(negedge clk);
    chk("resp_valid", 32'(resp_valid), 32'h1);
    chk("resp_data", resp_data, v.exp_data);
    chk("resp_id", 32'(resp_id), 32'(v.exp_id));
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 2'b00, 32'h0000000F, 32'h00000005, 4'b0001, 32'h00000005, 2'd0, 1'b0};
    vecs[1]  = '{4'b0001, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 32'hFFFFFFFF, 2'd0, 1'b0};
    vecs[2]  = '{4'b0100, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'hF000F000, 2'd2, 1'b0};
    vecs[3]  = '{4'b0100, 2'b01, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'hFFF0FFF0, 2'd2, 1'b0};
    vecs[4]  = '{4'b0100, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'h0FF00FF0, 2'd2, 1'b0};
    vecs[5]  = '{4'b0100, 2'b11, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0100, 32'h000F000F, 2'd2, 1'b0};
    vecs[6]  = '{4'b1000, 2'b11, 32'h00000000, 32'h00000000, 4'b1000, 32'hFFFFFFFF, 2'd3, 1'b0};
    vecs[7]  = '{4'b1111, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0001, 32'hAAAAAAAA, 2'd0, 1'b1};
    vecs[8]  = '{4'b1111, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0010, 32'hAAAAAAAA, 2'd1, 1'b1};
    vecs[9]  = '{4'b1111, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0100, 32'hAAAAAAAA, 2'd2, 1'b1};
    vecs[10] = '{4'b1111, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b1000, 32'hAAAAAAAA, 2'd3, 1'b1};
    vecs[11] = '{4'b1111, 2'b10, 32'hA5A5A5A5, 32'h0F0F0F0F, 4'b0001, 32'hAAAAAAAA, 2'd0, 1'b0};
    vecs[12] = '{4'b1000, 2'b01, 32'h12340000, 32'h00005678, 4'b1000, 32'h12345678, 2'd3, 1'b0};
    rst_n = 1'b0;
    req_valid = 4'b1111;
    resp_ready = 1'b0;
    drive_all(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 12; i++) txn(vecs[i]);
    // backpressure: requester 0 in flight (rr_ptr=1), requester 1 waits
    req_valid = 4'b0001;
    drive_all(2'b01, 32'hF0F0F0F0, 32'hFF00FF00);
    resp_ready = 1'b0;
    #1 chk("bp_accept", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 4'b0011;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_data", resp_data, 32'hFFF0FFF0);
      chk("bp_id", 32'(resp_id), 32'h0);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_hs_valid", 32'(resp_valid), 32'h0);
    chk("post_hs_data", resp_data, 32'hFFF0FFF0);
    chk("post_hs_id", 32'(resp_id), 32'h0);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(resp_valid), 32'h1);
    chk("pre_rst_id", 32'(resp_id), 32'h1);
    // async reset while the result is pending
    #2 rst_n = 1'b0;
    req_valid = 4'b1111;
    #1 chk("arst_valid", 32'(resp_valid), 32'h0);
    chk("arst_data", resp_data, 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b1001;
    #1 chk("rr_from_zero", 32'(req_ready), 32'h1);
    txn(vecs[12]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
